majority_voter_filt: RTL and testbench

- Parametrised, clocked successor to the lab's 4-input majority function: N-channel threshold voter.
- Registered inputs, popcount/vote pipeline, and a persistence filter. The filtered output changes only after HOLD consecutive valid samples disagree with it.
- Adds a saturating counter of non-unanimous samples for fault and glitch monitoring.
- Sits between raw sensor/channel inputs and downstream logic that needs a glitch-free voted decision.

---
 rtl/majority_voter_filt.sv | 175 +++++++++++++++++
 tb/tb_majority_voter_filt.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/majority_voter_filt.sv
// majority_voter_filt: N-channel threshold voter with registered inputs, a
// popcount/vote pipeline stage, a persistence filter that flips the decision
// only after HOLD consecutive disagreeing valid votes, and a saturating
// counter of non-unanimous samples for fault/glitch monitoring.
module majority_voter_filt #(
    parameter int N      = 4,
    parameter int THRESH = 2,
    parameter int HOLD   = 3,
    parameter int CNT_W  = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N-1:0]             inputs,
    input  logic                     in_valid,
    input  logic                     clr,
    output logic [$clog2(N+1)-1:0]   ones,
    output logic                     raw_vote,
    output logic                     vote_valid,
    output logic                     f_out,
    output logic                     changed,
    output logic [CNT_W-1:0]         disagree_cnt
);

    localparam int OW = $clog2(N + 1);
    localparam int RW = $clog2(HOLD + 1);

    localparam logic [OW-1:0]    THRESH_W = OW'(THRESH);
    localparam logic [OW-1:0]    N_W      = OW'(N);
    localparam logic [RW-1:0]    HOLD_W   = RW'(HOLD);
    localparam logic [RW-1:0]    RUN_ONE  = RW'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    // Reject parameter combinations that make the voter meaningless.
    generate
        if (N < 2) begin : g_badN
            $error("majority_voter_filt: N must be at least 2");
        end
        if ((THRESH < 1) || (THRESH > N)) begin : g_badThresh
            $error("majority_voter_filt: THRESH must satisfy 1 <= THRESH <= N");
        end
        if (HOLD < 1) begin : g_badHold
            $error("majority_voter_filt: HOLD must be at least 1");
        end
        if (CNT_W < 1) begin : g_badCntW
            $error("majority_voter_filt: CNT_W must be at least 1");
        end
    endgenerate

    typedef enum logic {
        STABLE  = 1'b0,
        PENDING = 1'b1
    } filtState_t;

    logic [N-1:0]     r_inQ;
    logic             r_v1;
    logic [OW-1:0]    r_ones;
    logic             r_rawVote;
    logic             r_voteValid;
    filtState_t       r_state;
    logic [RW-1:0]    r_run;
    logic             r_fOut;
    logic             r_changed;
    logic [CNT_W-1:0] r_disagreeCnt;

    logic [OW-1:0]    w_popcount;
    logic             w_vote;
    logic [RW-1:0]    w_runNext;
    logic             w_disagree;

    // Stage 1: capture the channel bits only when the sample is qualified.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inQ <= '0;
            r_v1  <= 1'b0;
        end else begin
            r_v1 <= in_valid;
            if (in_valid) begin
                r_inQ <= inputs;
            end
        end
    end

    // Count the ones in the captured sample; ties at THRESH vote 1.
    always_comb begin
        w_popcount = '0;
        for (int i = 0; i < N; i++) begin
            w_popcount = w_popcount + OW'(r_inQ[i]);
        end
        w_vote = (w_popcount >= THRESH_W);
    end

    // Stage 2: register popcount and raw vote; hold them between samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ones      <= '0;
            r_rawVote   <= 1'b0;
            r_voteValid <= 1'b0;
        end else begin
            r_voteValid <= r_v1;
            if (r_v1) begin
                r_ones    <= w_popcount;
                r_rawVote <= w_vote;
            end
        end
    end

    assign w_runNext  = r_run + RUN_ONE;
    assign w_disagree = r_voteValid && (r_ones != '0) && (r_ones != N_W);

    // Persistence filter: only vote_valid cycles advance or break the run,
    // idle cycles leave it untouched so gaps do not restart the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= STABLE;
            r_run     <= '0;
            r_fOut    <= 1'b0;
            r_changed <= 1'b0;
        end else begin
            r_changed <= 1'b0;
            if (r_voteValid) begin
                case (r_state)
                    STABLE: begin
                        if (r_rawVote != r_fOut) begin
                            if (HOLD == 1) begin
                                r_fOut    <= r_rawVote;
                                r_changed <= 1'b1;
                            end else begin
                                r_state <= PENDING;
                                r_run   <= RUN_ONE;
                            end
                        end
                    end
                    PENDING: begin
                        if (r_rawVote != r_fOut) begin
                            if (w_runNext == HOLD_W) begin
                                r_fOut    <= r_rawVote;
                                r_changed <= 1'b1;
                                r_run     <= '0;
                                r_state   <= STABLE;
                            end else begin
                                r_run <= w_runNext;
                            end
                        end else begin
                            r_run   <= '0;
                            r_state <= STABLE;
                        end
                    end
                    default: begin
                        r_run   <= '0;
                        r_state <= STABLE;
                    end
                endcase
            end
        end
    end

    // Saturating count of non-unanimous votes; clear takes priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_disagreeCnt <= '0;
        end else if (clr) begin
            r_disagreeCnt <= '0;
        end else if (w_disagree && (r_disagreeCnt != CNT_MAX)) begin
            r_disagreeCnt <= r_disagreeCnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign ones         = r_ones;
    assign raw_vote     = r_rawVote;
    assign vote_valid   = r_voteValid;
    assign f_out        = r_fOut;
    assign changed      = r_changed;
    assign disagree_cnt = r_disagreeCnt;

endmodule

// File: tb/tb_majority_voter_filt.sv
// Testbench for majority_voter_filt: directed scenarios plus randomized
// traffic, checked against a sample-history reference model.
module tb_majority_voter_filt;

    localparam int N      = 4;
    localparam int THRESH = 2;
    localparam int HOLD   = 3;
    localparam int CNT_W  = 8;
    localparam int OW     = $clog2(N + 1);
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst_n;
    logic [N-1:0]     inputs;
    logic             in_valid;
    logic             clr;
    logic [OW-1:0]    ones;
    logic             raw_vote;
    logic             vote_valid;
    logic             f_out;
    logic             changed;
    logic [CNT_W-1:0] disagree_cnt;

    majority_voter_filt #(
        .N      (N),
        .THRESH (THRESH),
        .HOLD   (HOLD),
        .CNT_W  (CNT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .inputs       (inputs),
        .in_valid     (in_valid),
        .clr          (clr),
        .ones         (ones),
        .raw_vote     (raw_vote),
        .vote_valid   (vote_valid),
        .f_out        (f_out),
        .changed      (changed),
        .disagree_cnt (disagree_cnt)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic         valid;
        logic [N-1:0] vec;
    } sample_t;

    // Reference model: history of per-edge input samples, outputs derived
    // from the age of each sample and the voting/filtering rules.
    sample_t hist[$];
    int expOnes, expRaw, expVv, expF, expChanged, expCnt, mRun;
    int checkCount, passCount;

    task automatic checkOutput(input string tag, input int obs, input int exp);
        checkCount++;
        if (obs == exp) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic modelReset();
        hist.delete();
        expOnes = 0; expRaw = 0; expVv = 0; expF = 0;
        expChanged = 0; expCnt = 0; mRun = 0;
    endtask

    // Advance the model by one clock edge with the inputs present at it.
    task automatic modelEdge(input logic v, input logic [N-1:0] vec, input logic c);
        int sz;
        int pc;
        int vote;
        sample_t s;
        s.valid = v;
        s.vec   = vec;
        hist.push_back(s);
        sz = hist.size();
        expChanged = 0;
        // Sample seen by the filter and counter: the vote that was valid last cycle.
        if (sz >= 3 && hist[sz-3].valid) begin
            pc   = $countones(hist[sz-3].vec);
            vote = (pc >= THRESH) ? 1 : 0;
            if (vote != expF) begin
                mRun++;
                if (mRun == HOLD) begin
                    expF       = vote;
                    expChanged = 1;
                    mRun       = 0;
                end
            end else begin
                mRun = 0;
            end
            if (pc > 0 && pc < N && expCnt < CNT_MAX) expCnt++;
        end
        if (c) expCnt = 0;
        // Sample becoming visible on ones/raw_vote after this edge.
        expVv = 0;
        if (sz >= 2 && hist[sz-2].valid) begin
            expVv   = 1;
            expOnes = $countones(hist[sz-2].vec);
            expRaw  = (expOnes >= THRESH) ? 1 : 0;
        end
        if (sz > 3) void'(hist.pop_front());
    endtask

    task automatic checkAll();
        checkOutput("ones",         int'(ones),         expOnes);
        checkOutput("raw_vote",     int'(raw_vote),     expRaw);
        checkOutput("vote_valid",   int'(vote_valid),   expVv);
        checkOutput("f_out",        int'(f_out),        expF);
        checkOutput("changed",      int'(changed),      expChanged);
        checkOutput("disagree_cnt", int'(disagree_cnt), expCnt);
    endtask

    // Drive one cycle of inputs, clock it, and compare just after the edge.
    task automatic applyStimulus(input logic v, input logic [N-1:0] vec, input logic c);
        in_valid = v;
        inputs   = vec;
        clr      = c;
        @(posedge clk);
        modelEdge(v, vec, c);
        #1;
        checkAll();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 4'b0000, 1'b0);
    endtask

    initial begin
        checkCount = 0;
        passCount  = 0;
        modelReset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        inputs   = '0;
        clr      = 1'b0;

        // Reset state, then idle traffic never raises vote_valid.
        #12;
        checkAll();
        #5 rst_n = 1'b1;
        idle(5);
        checkOutput("idle_vote_valid", int'(vote_valid), 0);

        // Single valid samples: one vote below threshold, then the tie case.
        applyStimulus(1'b1, 4'b1000, 1'b0);
        idle(1);
        checkOutput("lo_ones", int'(ones), 1);
        checkOutput("lo_raw", int'(raw_vote), 0);
        applyStimulus(1'b1, 4'b1100, 1'b0);
        idle(1);
        checkOutput("tie_ones", int'(ones), 2);
        checkOutput("tie_raw", int'(raw_vote), 1);
        checkOutput("tie_fout", int'(f_out), 0);
        applyStimulus(1'b1, 4'b0000, 1'b0);
        idle(3);

        // Three consecutive agreeing votes flip the output at t+5.
        applyStimulus(1'b1, 4'b1110, 1'b0);
        applyStimulus(1'b1, 4'b1110, 1'b0);
        applyStimulus(1'b1, 4'b1110, 1'b0);
        idle(1);
        checkOutput("flip_early_fout", int'(f_out), 0);
        idle(1);
        checkOutput("flip_fout", int'(f_out), 1);
        checkOutput("flip_changed", int'(changed), 1);
        idle(1);
        checkOutput("flip_changed_end", int'(changed), 0);

        // A two-sample glitch is absorbed.
        applyStimulus(1'b1, 4'b0000, 1'b0);
        applyStimulus(1'b1, 4'b0000, 1'b0);
        applyStimulus(1'b1, 4'b1111, 1'b0);
        idle(3);
        checkOutput("glitch_fout", int'(f_out), 1);

        // Bring output back to 0, then show idle gaps do not break a run.
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 4'b0000, 1'b0);
        idle(3);
        checkOutput("back_to_zero", int'(f_out), 0);
        applyStimulus(1'b1, 4'b0111, 1'b0);
        idle(4);
        applyStimulus(1'b1, 4'b0111, 1'b0);
        applyStimulus(1'b1, 4'b0111, 1'b0);
        idle(1);
        checkOutput("gap_pre_fout", int'(f_out), 0);
        idle(1);
        checkOutput("gap_fout", int'(f_out), 1);

        // Counter saturation, clear priority, unanimous samples ignored.
        for (int i = 0; i < 300; i++) applyStimulus(1'b1, 4'b0101, 1'b0);
        checkOutput("sat_cnt", int'(disagree_cnt), CNT_MAX);
        applyStimulus(1'b1, 4'b0011, 1'b1);
        checkOutput("clr_cnt", int'(disagree_cnt), 0);
        idle(3);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 4'b1111, 1'b0);
            applyStimulus(1'b1, 4'b0000, 1'b0);
        end
        idle(3);
        checkOutput("unanimous_cnt", int'(disagree_cnt), 2);

        // Asynchronous reset while a run of two is pending.
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 4'b0000, 1'b0);
        idle(3);
        applyStimulus(1'b1, 4'b1111, 1'b0);
        applyStimulus(1'b1, 4'b1111, 1'b0);
        idle(3);
        checkOutput("pend_fout", int'(f_out), 0);
        in_valid = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        modelReset();
        checkAll();
        @(negedge clk);
        #2 rst_n = 1'b1;
        applyStimulus(1'b1, 4'b1111, 1'b0);
        applyStimulus(1'b1, 4'b1111, 1'b0);
        idle(3);
        checkOutput("rst_run_lost", int'(f_out), 0);
        applyStimulus(1'b1, 4'b1111, 1'b0);
        idle(3);
        checkOutput("rst_refill", int'(f_out), 1);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
                          4'($urandom_range(0, 15)),
                          ($urandom_range(0, 31) == 0) ? 1'b1 : 1'b0);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
